midi_rx_deserializer: RTL

- On-cartridge MIDI receiver. Samples the raw MIDI input line at 31250 baud, frames 8N1 bytes and buffers them in a small FIFO.
- Presents the FIFO head, status and an interrupt request to the register read mux and data bus in the I/O-select block.
- Sits directly upstream of the cartridge register/bus-decode stage. It replaces the external UART's receive path when the MIDI port is selected.

---
 rtl/midi_rx_deserializer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/midi_rx_deserializer.sv
// MIDI 8N1 receiver: 2-flop input synchronizer, bit-centre sampling FSM and an 8-entry FWFT byte FIFO.
// Optional build macro MIDI_RX_REALTIME_FILTER_EN drops completed 8'hF8 / 8'hFE bytes instead of pushing them.
module midi_rx_deserializer #(
    parameter int CLKS_PER_BIT = 32,
    parameter int FIFO_AW      = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               midi_rxd,
    input  logic               rd_en,
    input  logic               clr_err,
    input  logic               irq_en,
    output logic [7:0]         rx_data,
    output logic [FIFO_AW:0]   rx_count,
    output logic               rx_empty,
    output logic               frame_err,
    output logic               overrun,
    output logic               irq
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int BW    = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] HALF_M1 = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] FULL_M1 = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t state_q, state_d;

    logic sync1_q, sync2_q, prev_q;
    logic rxd_s, fall;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic baud_zero;
    logic load_half, load_full, shift_en, byte_done, frame_set;

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               frame_err_q, overrun_q, irq_q;
    logic               full, pop, push_req, push_ok, overrun_set;

    // Synchronizer and edge-history flops idle at 1 so reset never looks like a start edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= midi_rxd;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rxd_s     = sync2_q;
    assign fall      = prev_q & ~rxd_s;
    assign baud_zero = (baud_q == '0);

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (fall) state_d = S_START;
            S_START:     if (baud_zero) state_d = rxd_s ? S_IDLE : S_DATA;
            S_DATA:      if (baud_zero && bit_cnt_q == 3'd7) state_d = S_STOP;
            S_STOP:      if (baud_zero) state_d = rxd_s ? S_IDLE : S_WAIT_IDLE;
            S_WAIT_IDLE: if (rxd_s) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        load_half = 1'b0;
        load_full = 1'b0;
        shift_en  = 1'b0;
        byte_done = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            S_IDLE:  load_half = fall;
            S_START: load_full = baud_zero & ~rxd_s;
            S_DATA: begin
                load_full = baud_zero;
                shift_en  = baud_zero;
            end
            S_STOP: begin
                byte_done = baud_zero & rxd_s;
                frame_set = baud_zero & ~rxd_s;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            baud_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            if (load_half)      baud_q <= HALF_M1;
            else if (load_full) baud_q <= FULL_M1;
            else if (!baud_zero) baud_q <= baud_q - 1'b1;

            if (load_half) begin
                bit_cnt_q <= '0;
            end else if (shift_en) begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
                shift_q   <= {rxd_s, shift_q[7:1]};
            end
        end
    end

`ifdef MIDI_RX_REALTIME_FILTER_EN
    // Timing clock and active sensing are discarded before they reach the FIFO, so they can never overrun it.
    assign push_req = byte_done & (shift_q != 8'hF8) & (shift_q != 8'hFE);
`else
    assign push_req = byte_done;
`endif

    assign full        = count_q[FIFO_AW];
    assign pop         = rd_en & (count_q != '0);
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push_ok     = push_req & (~full | pop);
    assign overrun_set = push_req & full & ~pop;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q     <= count_d;
            frame_err_q <= (frame_err_q & ~clr_err) | frame_set;
            overrun_q   <= (overrun_q & ~clr_err) | overrun_set;
            irq_q       <= irq_en & (count_q != '0);
        end
    end

    assign rx_empty  = (count_q == '0);
    assign rx_count  = count_q;
    assign rx_data   = rx_empty ? 8'h00 : mem_q[rd_ptr_q];
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign irq       = irq_q;
endmodule
